// File: rtl/rob_mw.sv
// Multi-wide reorder buffer: in-order alloc, out-of-order completion, in-order retire
// with head-flush nuke, quiesce, backward RAT-restore walk and fetch resume.
module rob_mw #(
    parameter int NUM_ENTS    = 32,
    parameter int ALLOC_W     = 2,
    parameter int RETIRE_W    = 2,
    parameter int RESTORE_W   = 2,
    parameter int NUM_CPL     = 3,
    parameter int QUIESCE_CYC = 5,
    parameter int GPR_W       = 5,
    parameter int PRF_W       = 7,
    parameter int RID_W       = $clog2(NUM_ENTS) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         rob_ready,
    input  logic [ALLOC_W-1:0]           alloc_vld,
    input  logic [ALLOC_W-1:0]           alloc_dst_vld,
    input  logic [ALLOC_W*GPR_W-1:0]     alloc_gpr,
    input  logic [ALLOC_W*PRF_W-1:0]     alloc_pdst_old,
    output logic [ALLOC_W*RID_W-1:0]     alloc_robid,
    input  logic [NUM_CPL-1:0]           cpl_vld,
    input  logic [NUM_CPL*RID_W-1:0]     cpl_robid,
    input  logic [NUM_CPL-1:0]           cpl_flush,
    input  logic [NUM_CPL-1:0]           cpl_mispred,
    output logic [RETIRE_W-1:0]          ret_vld,
    output logic [RETIRE_W*RID_W-1:0]    ret_robid,
    output logic [RETIRE_W-1:0]          reclaim_vld,
    output logic [RETIRE_W*PRF_W-1:0]    reclaim_prfid,
    output logic                         nuke_vld,
    output logic                         nuke_mispred,
    output logic [RESTORE_W-1:0]         restore_vld,
    output logic [RESTORE_W*GPR_W-1:0]   restore_gpr,
    output logic [RESTORE_W*PRF_W-1:0]   restore_prfid,
    output logic                         resume_fetch,
    output logic [RID_W-1:0]             oldest_robid,
    output logic [$clog2(NUM_ENTS):0]    free_cnt
);

    localparam int IDX_W = $clog2(NUM_ENTS);
    localparam int QC_W  = $clog2(QUIESCE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_QUIET, S_WALK, S_RESUME} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_ENTS-1:0] r_vld;
    logic [NUM_ENTS-1:0] r_rdy;
    logic [NUM_ENTS-1:0] r_flush;
    logic [NUM_ENTS-1:0] r_mispred;
    logic [NUM_ENTS-1:0] r_dst;
    logic [GPR_W-1:0]    r_gpr  [NUM_ENTS];
    logic [PRF_W-1:0]    r_pold [NUM_ENTS];

    logic [RID_W-1:0]    r_head;
    logic [RID_W-1:0]    r_tail;
    logic [RID_W-1:0]    r_walk;
    logic [RID_W-1:0]    r_last;
    logic [QC_W-1:0]     r_qcnt;

    logic                w_idle;
    logic [RID_W-1:0]    w_occ;
    logic [RID_W-1:0]    w_rem;
    logic [ALLOC_W-1:0]  w_alloc_go;
    logic [RID_W-1:0]    w_alloc_cnt;
    logic [RID_W-1:0]    w_ret_cnt;
    logic                w_chain;
    logic [RID_W-1:0]    w_ret_id [RETIRE_W];
    logic [RID_W-1:0]    w_rst_id [RESTORE_W];
    logic [RID_W-1:0]    w_cpl_id [NUM_CPL];
    logic [NUM_CPL-1:0]  w_cpl_hit;
    logic [IDX_W-1:0]    w_hidx;

    assign w_idle       = (r_state == S_IDLE);
    assign w_occ        = r_tail - r_head;
    assign free_cnt     = RID_W'(NUM_ENTS) - w_occ;
    assign rob_ready    = (free_cnt >= RID_W'(ALLOC_W)) && w_idle;
    assign oldest_robid = r_head;
    assign resume_fetch = (r_state == S_RESUME);
    assign w_rem        = r_walk - r_last;
    assign w_hidx       = r_head[IDX_W-1:0];

    always_comb begin
        alloc_robid = '0;
        w_alloc_cnt = '0;
        w_alloc_go  = rob_ready ? alloc_vld : '0;
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
            alloc_robid[i*RID_W +: RID_W] = r_tail + RID_W'(i);
            w_alloc_cnt = w_alloc_cnt + RID_W'(w_alloc_go[i]);
        end
    end

    // A completion only lands on a live entry inside [head, tail).
    always_comb begin
        w_cpl_hit = '0;
        for (int unsigned p = 0; p < NUM_CPL; p++) begin
            w_cpl_id[p]  = cpl_robid[p*RID_W +: RID_W];
            w_cpl_hit[p] = w_idle && cpl_vld[p] && r_vld[w_cpl_id[p][IDX_W-1:0]]
                           && ((w_cpl_id[p] - r_head) < w_occ);
        end
    end

    always_comb begin
        ret_vld       = '0;
        ret_robid     = '0;
        reclaim_vld   = '0;
        reclaim_prfid = '0;
        nuke_vld      = 1'b0;
        nuke_mispred  = 1'b0;
        w_ret_cnt     = '0;
        w_chain       = w_idle;
        for (int unsigned k = 0; k < RETIRE_W; k++)
            w_ret_id[k] = r_head + RID_W'(k);
        if (w_idle && r_vld[w_hidx] && r_rdy[w_hidx] && r_flush[w_hidx]) begin
            nuke_vld                 = 1'b1;
            nuke_mispred             = r_mispred[w_hidx];
            ret_vld[0]               = 1'b1;
            ret_robid[0 +: RID_W]    = r_head;
            reclaim_vld[0]           = r_dst[w_hidx];
            reclaim_prfid[0 +: PRF_W] = r_pold[w_hidx];
            w_ret_cnt                = RID_W'(1);
        end else begin
            for (int unsigned k = 0; k < RETIRE_W; k++) begin
                w_chain = w_chain && r_vld[w_ret_id[k][IDX_W-1:0]] && r_rdy[w_ret_id[k][IDX_W-1:0]]
                          && !r_flush[w_ret_id[k][IDX_W-1:0]];
                if (w_chain) begin
                    ret_vld[k]                   = 1'b1;
                    ret_robid[k*RID_W +: RID_W]  = w_ret_id[k];
                    reclaim_vld[k]               = r_dst[w_ret_id[k][IDX_W-1:0]];
                    reclaim_prfid[k*PRF_W +: PRF_W] = r_pold[w_ret_id[k][IDX_W-1:0]];
                    w_ret_cnt                    = w_ret_cnt + RID_W'(1);
                end
            end
        end
    end

    // Walk lane j covers walkptr-j while it has not passed below the surviving head.
    always_comb begin
        restore_vld   = '0;
        restore_gpr   = '0;
        restore_prfid = '0;
        for (int unsigned j = 0; j < RESTORE_W; j++) begin
            w_rst_id[j] = r_walk - RID_W'(j);
            restore_gpr[j*GPR_W +: GPR_W]   = r_gpr[w_rst_id[j][IDX_W-1:0]];
            restore_prfid[j*PRF_W +: PRF_W] = r_pold[w_rst_id[j][IDX_W-1:0]];
            restore_vld[j] = (r_state == S_WALK) && (RID_W'(j) <= w_rem)
                             && r_vld[w_rst_id[j][IDX_W-1:0]] && r_dst[w_rst_id[j][IDX_W-1:0]];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (nuke_vld) w_state_nxt = S_QUIET;
            S_QUIET:  if (r_qcnt == '0)
                          w_state_nxt = (r_walk + RID_W'(1) == r_last) ? S_RESUME : S_WALK;
            S_WALK:   if (w_rem < RID_W'(RESTORE_W)) w_state_nxt = S_RESUME;
            S_RESUME: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= '0;
            r_rdy     <= '0;
            r_flush   <= '0;
            r_mispred <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_walk    <= '0;
            r_last    <= '0;
            r_qcnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    for (int unsigned p = 0; p < NUM_CPL; p++) begin
                        if (w_cpl_hit[p]) begin
                            r_rdy[w_cpl_id[p][IDX_W-1:0]]     <= 1'b1;
                            r_flush[w_cpl_id[p][IDX_W-1:0]]   <= cpl_flush[p];
                            r_mispred[w_cpl_id[p][IDX_W-1:0]] <= cpl_mispred[p];
                        end
                    end
                    for (int unsigned k = 0; k < RETIRE_W; k++) begin
                        if (ret_vld[k]) begin
                            r_vld[w_ret_id[k][IDX_W-1:0]]     <= 1'b0;
                            r_rdy[w_ret_id[k][IDX_W-1:0]]     <= 1'b0;
                            r_flush[w_ret_id[k][IDX_W-1:0]]   <= 1'b0;
                            r_mispred[w_ret_id[k][IDX_W-1:0]] <= 1'b0;
                        end
                    end
                    for (int unsigned i = 0; i < ALLOC_W; i++) begin
                        if (w_alloc_go[i]) begin
                            r_vld[IDX_W'(r_tail + RID_W'(i))]     <= 1'b1;
                            r_rdy[IDX_W'(r_tail + RID_W'(i))]     <= 1'b0;
                            r_flush[IDX_W'(r_tail + RID_W'(i))]   <= 1'b0;
                            r_mispred[IDX_W'(r_tail + RID_W'(i))] <= 1'b0;
                            r_dst[IDX_W'(r_tail + RID_W'(i))]     <= alloc_dst_vld[i];
                            r_gpr[IDX_W'(r_tail + RID_W'(i))]     <= alloc_gpr[i*GPR_W +: GPR_W];
                            r_pold[IDX_W'(r_tail + RID_W'(i))]    <= alloc_pdst_old[i*PRF_W +: PRF_W];
                        end
                    end
                    r_head <= r_head + w_ret_cnt;
                    r_tail <= r_tail + w_alloc_cnt;
                    // Walk start uses the post-alloc tail so a same-cycle group is also unwound.
                    if (nuke_vld) begin
                        r_walk <= r_tail + w_alloc_cnt - RID_W'(1);
                        r_last <= r_head + RID_W'(1);
                        r_qcnt <= QC_W'(QUIESCE_CYC - 1);
                    end
                end
                S_QUIET:  if (r_qcnt != '0) r_qcnt <= r_qcnt - QC_W'(1);
                S_WALK:   r_walk <= r_walk - RID_W'(RESTORE_W);
                S_RESUME: begin
                    r_vld     <= '0;
                    r_rdy     <= '0;
                    r_flush   <= '0;
                    r_mispred <= '0;
                    r_tail    <= r_head;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (|alloc_vld)
                assert (rob_ready) else $error("rob_mw: alloc while not ready");
            assert ((alloc_vld & (alloc_vld + ALLOC_W'(1))) == '0)
                else $error("rob_mw: non-contiguous alloc_vld");
            for (int unsigned p = 0; p < NUM_CPL; p++) begin
                for (int unsigned q = p + 1; q < NUM_CPL; q++) begin
                    if (cpl_vld[p] && cpl_vld[q])
                        assert (w_cpl_id[p] != w_cpl_id[q]) else $error("rob_mw: duplicate completion id");
                end
                if (w_cpl_hit[p])
                    assert (!r_rdy[w_cpl_id[p][IDX_W-1:0]]) else $error("rob_mw: completion of ready entry");
            end
        end
    end

endmodule

// File: tb/tb_rob_mw.sv
// Directed bench for rob_mw: fill, wrap, partial retire, nuke walks and reset mid-walk.
module tb_rob_mw;

    logic        clk;
    logic        reset;
    logic        rob_ready;
    logic [1:0]  alloc_vld;
    logic [1:0]  alloc_dst_vld;
    logic [9:0]  alloc_gpr;
    logic [13:0] alloc_pdst_old;
    logic [11:0] alloc_robid;
    logic [2:0]  cpl_vld;
    logic [17:0] cpl_robid;
    logic [2:0]  cpl_flush;
    logic [2:0]  cpl_mispred;
    logic [1:0]  ret_vld;
    logic [11:0] ret_robid;
    logic [1:0]  reclaim_vld;
    logic [13:0] reclaim_prfid;
    logic        nuke_vld;
    logic        nuke_mispred;
    logic [1:0]  restore_vld;
    logic [9:0]  restore_gpr;
    logic [13:0] restore_prfid;
    logic        resume_fetch;
    logic [5:0]  oldest_robid;
    logic [5:0]  free_cnt;

    int vecs = 0;
    int miscomp = 0;
    int nid = 0;

    rob_mw #(
        .NUM_ENTS(32), .ALLOC_W(2), .RETIRE_W(2), .RESTORE_W(2), .NUM_CPL(3),
        .QUIESCE_CYC(5), .GPR_W(5), .PRF_W(7)
    ) dut (
        .clk(clk), .reset(reset), .rob_ready(rob_ready),
        .alloc_vld(alloc_vld), .alloc_dst_vld(alloc_dst_vld), .alloc_gpr(alloc_gpr),
        .alloc_pdst_old(alloc_pdst_old), .alloc_robid(alloc_robid),
        .cpl_vld(cpl_vld), .cpl_robid(cpl_robid), .cpl_flush(cpl_flush), .cpl_mispred(cpl_mispred),
        .ret_vld(ret_vld), .ret_robid(ret_robid), .reclaim_vld(reclaim_vld),
        .reclaim_prfid(reclaim_prfid), .nuke_vld(nuke_vld), .nuke_mispred(nuke_mispred),
        .restore_vld(restore_vld), .restore_gpr(restore_gpr), .restore_prfid(restore_prfid),
        .resume_fetch(resume_fetch), .oldest_robid(oldest_robid), .free_cnt(free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscomp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        alloc_vld = '0; alloc_dst_vld = '0; alloc_gpr = '0; alloc_pdst_old = '0;
        cpl_vld = '0; cpl_robid = '0; cpl_flush = '0; cpl_mispred = '0;
    endtask

    // Entry with tb id n carries gpr = n mod 32 and pdst_old = (n + 40) mod 128.
    task automatic set_alloc(input logic [1:0] v);
        alloc_vld      = v;
        alloc_dst_vld  = v;
        alloc_gpr      = {5'(nid + 1), 5'(nid)};
        alloc_pdst_old = {7'(nid + 41), 7'(nid + 40)};
        nid = nid + int'(v[0]) + int'(v[1]);
    endtask

    task automatic set_cpl(input int p, input int id, input logic f, input logic m);
        cpl_vld[p]          = 1'b1;
        cpl_robid[p*6 +: 6] = 6'(id);
        cpl_flush[p]        = f;
        cpl_mispred[p]      = m;
    endtask

    task automatic do_reset;
        clr_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nid = 0;
    endtask

    task automatic setup_nuke7;
        do_reset();
        for (int g = 0; g < 3; g++) begin
            set_alloc(2'b11);
            step();
        end
        set_alloc(2'b01);
        step();
        clr_in();
        set_cpl(0, 0, 1'b1, 1'b1);
        step();
        clr_in();
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        chk("rst_ready", rob_ready, 1);
        chk("rst_free", free_cnt, 32);
        chk("rst_alloc_id", alloc_robid, {6'd1, 6'd0});
        chk("rst_ret", ret_vld, 0);
        chk("rst_reclaim", reclaim_vld, 0);
        chk("rst_nuke", nuke_vld, 0);
        chk("rst_restore", restore_vld, 0);
        chk("rst_resume", resume_fetch, 0);
        chk("rst_oldest", oldest_robid, 0);

        // Fill 16 groups of 2
        for (int g = 0; g < 16; g++) begin
            if (g == 15) begin
                chk("fill_free15", free_cnt, 2);
                chk("fill_ready15", rob_ready, 1);
            end
            chk("fill_id", alloc_robid, {6'(2*g + 1), 6'(2*g)});
            set_alloc(2'b11);
            step();
        end
        clr_in();
        chk("full_free", free_cnt, 0);
        chk("full_ready", rob_ready, 0);
        set_cpl(0, 0, 1'b0, 1'b0);
        set_cpl(1, 1, 1'b0, 1'b0);
        set_cpl(2, 2, 1'b0, 1'b0);
        step();
        clr_in();
        chk("cpl_ret1", ret_vld, 2'b11);
        chk("cpl_ret1_id", ret_robid, {6'd1, 6'd0});
        chk("cpl_reclaim1", reclaim_vld, 2'b11);
        chk("cpl_reclaim1_prf", reclaim_prfid, {7'd41, 7'd40});
        set_cpl(0, 3, 1'b0, 1'b0);
        step();
        clr_in();
        chk("cpl_ret2", ret_vld, 2'b11);
        chk("cpl_ret2_id", ret_robid, {6'd3, 6'd2});
        step();
        chk("cpl_ret3", ret_vld, 0);
        chk("cpl_head", oldest_robid, 4);
        chk("cpl_free", free_cnt, 4);
        chk("cpl_ready", rob_ready, 1);

        // Wrap: stream 40 entries, completing each group one cycle after alloc
        do_reset();
        for (int c = 0; c < 22; c++) begin
            clr_in();
            if (c < 20) begin
                chk("wrap_alloc_id", alloc_robid, {6'(2*c + 1), 6'(2*c)});
                set_alloc(2'b11);
            end
            if (c >= 1 && c <= 20) begin
                set_cpl(0, 2*c - 2, 1'b0, 1'b0);
                set_cpl(1, 2*c - 1, 1'b0, 1'b0);
            end
            if (c >= 2) begin
                chk("wrap_ret", ret_vld, 2'b11);
                chk("wrap_ret_id", ret_robid, {6'(2*c - 3), 6'(2*c - 4)});
            end
            step();
        end
        clr_in();
        chk("wrap_head", oldest_robid, 6'h28);
        chk("wrap_empty_free", free_cnt, 32);
        chk("wrap_empty_ready", rob_ready, 1);
        for (int g = 0; g < 16; g++) begin
            set_alloc(2'b11);
            step();
        end
        clr_in();
        chk("wrap_full_free", free_cnt, 0);
        chk("wrap_full_ready", rob_ready, 0);
        chk("wrap_full_tail", alloc_robid, {6'd9, 6'd8});
        chk("wrap_full_head", oldest_robid, 6'h28);

        // Partial retire
        do_reset();
        set_alloc(2'b11);
        step();
        clr_in();
        set_alloc(2'b01);
        step();
        clr_in();
        set_cpl(0, 1, 1'b0, 1'b0);
        set_cpl(1, 2, 1'b0, 1'b0);
        step();
        clr_in();
        chk("part_noret", ret_vld, 0);
        chk("part_head0", oldest_robid, 0);
        set_cpl(0, 0, 1'b0, 1'b0);
        step();
        clr_in();
        chk("part_ret01", ret_vld, 2'b11);
        chk("part_ret01_id", ret_robid, {6'd1, 6'd0});
        step();
        chk("part_ret2", ret_vld, 2'b01);
        chk("part_ret2_id", ret_robid[5:0], 2);
        step();
        chk("part_idle", ret_vld, 0);
        chk("part_head3", oldest_robid, 3);
        chk("part_free", free_cnt, 32);

        // Mispredict nuke with 6 younger entries
        setup_nuke7();
        chk("mp_nuke", nuke_vld, 1);
        chk("mp_cause", nuke_mispred, 1);
        chk("mp_ret", ret_vld, 2'b01);
        chk("mp_ret_id", ret_robid[5:0], 0);
        chk("mp_reclaim", reclaim_vld, 2'b01);
        chk("mp_reclaim_prf", reclaim_prfid[6:0], 40);
        chk("mp_ready_n", rob_ready, 1);
        step();
        for (int q = 0; q < 5; q++) begin
            chk("mp_quiet_restore", restore_vld, 0);
            chk("mp_quiet_ready", rob_ready, 0);
            chk("mp_quiet_nuke", nuke_vld, 0);
            step();
        end
        chk("mp_walk1", restore_vld, 2'b11);
        chk("mp_walk1_gpr", restore_gpr, {5'd5, 5'd6});
        chk("mp_walk1_prf", restore_prfid, {7'd45, 7'd46});
        step();
        chk("mp_walk2", restore_vld, 2'b11);
        chk("mp_walk2_gpr", restore_gpr, {5'd3, 5'd4});
        chk("mp_walk2_prf", restore_prfid, {7'd43, 7'd44});
        step();
        chk("mp_walk3", restore_vld, 2'b11);
        chk("mp_walk3_gpr", restore_gpr, {5'd1, 5'd2});
        chk("mp_walk3_prf", restore_prfid, {7'd41, 7'd42});
        step();
        chk("mp_resume", resume_fetch, 1);
        chk("mp_resume_restore", restore_vld, 0);
        chk("mp_resume_ready", rob_ready, 0);
        step();
        chk("mp_idle_ready", rob_ready, 1);
        chk("mp_idle_resume", resume_fetch, 0);
        chk("mp_idle_head", oldest_robid, 1);
        chk("mp_idle_free", free_cnt, 32);
        chk("mp_idle_tail", alloc_robid, {6'd2, 6'd1});

        // Single-entry exception nuke
        do_reset();
        set_alloc(2'b01);
        step();
        clr_in();
        set_cpl(0, 0, 1'b1, 1'b0);
        step();
        clr_in();
        chk("ex_nuke", nuke_vld, 1);
        chk("ex_cause", nuke_mispred, 0);
        chk("ex_reclaim", reclaim_vld, 2'b01);
        step();
        for (int q = 0; q < 5; q++) begin
            chk("ex_quiet_restore", restore_vld, 0);
            chk("ex_quiet_resume", resume_fetch, 0);
            step();
        end
        chk("ex_resume", resume_fetch, 1);
        chk("ex_resume_restore", restore_vld, 0);
        step();
        chk("ex_idle_ready", rob_ready, 1);
        chk("ex_idle_head", oldest_robid, 1);
        chk("ex_idle_free", free_cnt, 32);

        // Reset during the second walk cycle
        setup_nuke7();
        step();
        for (int q = 0; q < 5; q++) step();
        chk("rw_walk1", restore_vld, 2'b11);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_ready", rob_ready, 1);
        chk("rw_free", free_cnt, 32);
        chk("rw_restore", restore_vld, 0);
        chk("rw_resume", resume_fetch, 0);
        chk("rw_head", oldest_robid, 0);
        step();
        chk("rw_restore2", restore_vld, 0);
        chk("rw_resume2", resume_fetch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
        $finish;
    end

endmodule
